// File: rtl/seven_seg_scroll_display.sv
// Time-multiplexed N-digit seven-segment driver with a scrolling, per-digit-blankable buffer.
// Define SEVEN_SEG_DP_EN to add the per-digit decimal point input seg_dp.
module seven_seg_scroll_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            seg_data,
    input  logic                  seg_write,
    input  logic                  seg_shift,
    input  logic                  seg_dir,
    input  logic                  seg_clear,
    input  logic                  seg_off,
`ifdef SEVEN_SEG_DP_EN
    input  logic                  seg_dp,
`endif
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [7:0]            cathodes
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic             INACTIVE = (ACTIVE_LOW != 0);

    // Active-high segment pattern {g..a} for a hex nibble.
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
        endcase
    endfunction

    logic dp_in;
`ifdef SEVEN_SEG_DP_EN
    assign dp_in = seg_dp;
`else
    assign dp_in = 1'b0;
`endif

    logic [NUM_DIGITS-1:0][3:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]      blank_q, blank_d;
    logic [NUM_DIGITS-1:0]      dp_q, dp_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]      anodes_q, anodes_d;
    logic [7:0]                 cathodes_q, cathodes_d;
    logic [IDX_W-1:0]           slot;
    logic [NUM_DIGITS-1:0]      sel;
    logic [7:0]                 lit;

    assign slot = seg_dir ? IDX_LAST : '0;

    // Clear dominates; a shift+write shifts first, then loads the freshly vacated entry slot.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        val_d   = val_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        if (seg_clear) begin
            blank_d = '1;
            dp_d    = '0;
        end else begin
            if (seg_shift) begin
                if (seg_dir) begin
                    val_d   = {4'h0, val_q[NUM_DIGITS-1:1]};
                    blank_d = {1'b1, blank_q[NUM_DIGITS-1:1]};
                    dp_d    = {1'b0, dp_q[NUM_DIGITS-1:1]};
                end else begin
                    val_d   = {val_q[NUM_DIGITS-2:0], 4'h0};
                    blank_d = {blank_q[NUM_DIGITS-2:0], 1'b1};
                    dp_d    = {dp_q[NUM_DIGITS-2:0], 1'b0};
                end
            end
            if (seg_write) begin
                val_d[slot]   = seg_data;
                blank_d[slot] = 1'b0;
                dp_d[slot]    = dp_in;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Both pins are decoded from the same index and buffer, so they switch on one edge.
    always_comb begin
        sel        = '0;
        sel[idx_q] = 1'b1;
        if (seg_off) begin
            sel = '0;
        end
        lit        = blank_q[idx_q] ? 8'h00 : {dp_q[idx_q], hex_font(val_q[idx_q])};
        anodes_d   = INACTIVE ? ~sel : sel;
        cathodes_d = INACTIVE ? ~lit : lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is small and its blank flags must be defined, so it is reset too.
            val_q      <= '0;
            blank_q    <= '1;
            dp_q       <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            anodes_q   <= {NUM_DIGITS{INACTIVE}};
            cathodes_q <= {8{INACTIVE}};
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            val_q      <= val_d;
            blank_q    <= blank_d;
            dp_q       <= dp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign anodes   = anodes_q;
    assign cathodes = cathodes_q;
endmodule

// File: tb/tb_seven_seg_scroll_display.sv
// Randomized self-checking bench for seven_seg_scroll_display (4 digits, divide-by-4, active-low).
module tb_seven_seg_scroll_display;
    localparam int N = 4;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] seg_data = '0;
    logic       seg_write = 1'b0;
    logic       seg_shift = 1'b0;
    logic       seg_dir = 1'b0;
    logic       seg_clear = 1'b0;
    logic       seg_off = 1'b0;
    logic [N-1:0] anodes;
    logic [7:0]   cathodes;

    seven_seg_scroll_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_data  (seg_data),
        .seg_write (seg_write),
        .seg_shift (seg_shift),
        .seg_dir   (seg_dir),
        .seg_clear (seg_clear),
        .seg_off   (seg_off),
`ifdef SEVEN_SEG_DP_EN
        .seg_dp    (1'b0),
`endif
        .anodes    (anodes),
        .cathodes  (cathodes)
    );

    always #5 clk = ~clk;

    // Active-low hex font, dp off.
    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: buffer contents and number of edges since reset released.
    int         mval [N];
    bit         mblank [N];
    int         n_edges;
    logic [7:0] obs [N];
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mval[i]   = 0;
            mblank[i] = 1'b1;
        end
        n_edges = 0;
    endtask

    task automatic do_reset(input bit busy);
        @(negedge clk);
        rst       = 1'b1;
        seg_write = busy;
        seg_shift = busy;
        seg_data  = 4'h5;
        @(posedge clk);
        #1;
        check("rst_anodes", anodes, 4'hF);
        check("rst_cathodes", cathodes, 8'hFF);
        model_reset();
    endtask

    task automatic cycle(input bit clr, input bit sh, input bit wr, input bit dir,
                         input logic [3:0] data, input bit off);
        logic [3:0] ea;
        logic [7:0] ec;
        int         d;
        int         s;
        @(negedge clk);
        rst = 1'b0; seg_clear = clr; seg_shift = sh; seg_write = wr;
        seg_dir = dir; seg_data = data; seg_off = off;
        // Outputs at this edge show the buffer and scan position as they stood before it.
        d  = (n_edges / R) % N;
        ea = off ? 4'hF : ~(4'b0001 << d);
        ec = mblank[d] ? 8'hFF : font[mval[d]];
        if (clr) begin
            for (int i = 0; i < N; i++) mblank[i] = 1'b1;
        end else begin
            if (sh) begin
                if (!dir) begin
                    for (int i = N - 1; i > 0; i--) begin
                        mval[i] = mval[i-1]; mblank[i] = mblank[i-1];
                    end
                    mblank[0] = 1'b1;
                end else begin
                    for (int i = 0; i < N - 1; i++) begin
                        mval[i] = mval[i+1]; mblank[i] = mblank[i+1];
                    end
                    mblank[N-1] = 1'b1;
                end
            end
            if (wr) begin
                s = dir ? N - 1 : 0;
                mval[s]   = int'(data);
                mblank[s] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        n_edges++;
        check("anodes", anodes, ea);
        check("cathodes", cathodes, ec);
        for (int i = 0; i < N; i++)
            if (anodes == ~(4'b0001 << i)) obs[i] = cathodes;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(0, 0, 0, 0, 4'h0, 0);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < N; i++) obs[i] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset(0);
        clear_obs();
        idle(32);
        for (int i = 0; i < N; i++) check("idle_blank", obs[i], 8'hFF);

        cycle(0, 1, 1, 0, 4'h9, 0);
        cycle(0, 1, 1, 0, 4'h8, 0);
        cycle(0, 1, 1, 0, 4'h7, 0);
        cycle(0, 1, 1, 0, 4'h6, 0);
        clear_obs();
        idle(16);
        check("shiftin_d0", obs[0], 8'h82);
        check("shiftin_d3", obs[3], 8'h90);

        cycle(0, 1, 0, 1, 4'h0, 0);
        clear_obs();
        idle(16);
        check("shiftdown_d3", obs[3], 8'hFF);
        check("shiftdown_d0", obs[0], 8'hF8);

        cycle(1, 0, 1, 0, 4'hA, 0);
        clear_obs();
        idle(16);
        for (int i = 0; i < N; i++) check("clear_wins", obs[i], 8'hFF);

        cycle(0, 0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 4'h0, 1);
        clear_obs();
        idle(16);
        check("after_off_d0", obs[0], 8'hC0);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);

        for (int i = 0; i < N; i++) cycle(0, 1, 1, 0, 4'($urandom_range(0, 15)), 0);
        idle(6);
        do_reset(1);
        clear_obs();
        idle(32);
        for (int i = 0; i < N; i++) check("post_rst_blank", obs[i], 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scroll_display.md
# seven_seg_scroll_display

Parametrised multi-digit seven-segment driver with a scrolling character buffer. It replaces the fixed 8-digit display stage fed by `scrolling_controller`, and keeps the same command interface (`seg_data`, `seg_off`, `seg_shift`, `seg_write`, `seg_clear`). It adds:
- configurable digit count, refresh rate and output polarity;
- per-digit blanking;
- selectable scroll direction.

It time-multiplexes the buffer onto shared `anodes`/`cathodes` pins.

## Interface
- `NUM_DIGITS`, 8: digits in buffer and on `anodes`; range 2..16.
- `REFRESH_DIV`, 1000: clock cycles each digit stays selected; minimum 2.
- `ACTIVE_LOW`, 1: 1 means anodes and cathodes are active-low; 0 means active-high.
- `clk` input 1: system clock.
- `rst` input 1: reset; synchronous, active-high.
- `seg_data` input 4: hex nibble for the digit being loaded.
- `seg_write` input 1: load `seg_data` into the entry slot (see Operation).
- `seg_shift` input 1: scroll the buffer by one digit.
- `seg_dir` input 1: scroll direction. 0 = toward higher index, entry slot is digit 0. 1 = toward lower index, entry slot is digit `NUM_DIGITS-1`.
- `seg_clear` input 1: blank all digits.
- `seg_off` input 1: level input; while high, all anodes are inactive.
- `anodes` output `NUM_DIGITS`: one-hot digit select.
- `cathodes` output 8: bit 7 = dp, bits 6..0 = segments g..a.

## Operation
- Buffer: `NUM_DIGITS` entries. Each entry holds a 4-bit value and a blank flag (blank=1 shows all segments off).
- Command priority, evaluated per cycle: `seg_clear` > (`seg_shift`, `seg_write`).
  - `seg_clear`: all entries blank.
  - `seg_shift` alone: entries move one place in the `seg_dir` direction. The entry slot becomes blank. The digit shifted out is discarded.
  - `seg_shift` and `seg_write` together: shift, then the entry slot takes `seg_data` with blank=0 (shift-in).
  - `seg_write` alone: the entry slot is overwritten with `seg_data`, blank=0; no movement.
- Scan:
  - The refresh counter counts 0..`REFRESH_DIV-1`.
  - At the terminal count the counter returns to 0 and the scan index advances by one.
  - The scan index wraps from `NUM_DIGITS-1` to 0.
- Decode: standard hex font 0..F, with segments a..g in bits 0..6. Active-low values:
  - 0 = 0xC0, 1 = 0xF9, 8 = 0x80, 9 = 0x90, A = 0x88, F = 0x8E.
  - When `ACTIVE_LOW`=0, all outputs are the bitwise inverse.
- A blank entry drives all 8 cathode bits inactive.
- `seg_off` forces all anodes inactive. Buffer, counter and scan keep running; commands are still accepted.

## Timing
- All state and both outputs are registered; no combinational input-to-output path.
- Reset (one `rst` cycle suffices, including mid-scan or mid-command):
  - buffer all blank, refresh counter 0, scan index 0;
  - `anodes` all inactive, `cathodes` all inactive (0xFF when `ACTIVE_LOW`=1).
- First cycle after `rst` deasserts: `anodes` selects digit 0 at the next edge.
- Each digit is held for exactly `REFRESH_DIV` cycles. A full frame is `NUM_DIGITS*REFRESH_DIV` cycles.
- Anodes and cathodes change on the same edge, so there is no ghosting cycle.
- Command latency:
  - A command sampled at edge k updates the buffer at edge k.
  - The outputs reflect the update at edge k+1 if the affected digit is currently scanned.
- A command that coincides with a scan-index advance: the outputs at k+1 show the new index with the updated buffer.
- Commands are single-cycle pulses. Holding `seg_shift` high shifts once per cycle.
- `seg_clear` with `seg_shift`/`seg_write` in the same cycle: clear wins and the other commands are dropped.

## Configuration
- `SEVEN_SEG_DP_EN` defined:
  - adds input `seg_dp` (1 bit);
  - `seg_dp` is stored per entry on writes and moves with the entry on shifts;
  - it drives cathode bit 7 when the entry is not blank;
  - clear resets all dp bits to 0.
- Undefined: no `seg_dp` port; cathode bit 7 is permanently inactive.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=4, `ACTIVE_LOW`=1.
- Reset, then idle 32 cycles:
  - `anodes` cycles 0xE, 0xD, 0xB, 0x7, 4 cycles each;
  - `cathodes` = 0xFF throughout.
- `seg_dir`=0; shift+write 9, 8, 7, 6 on consecutive cycles: digit 0 shows 0x82 (6), digit 3 shows 0x90 (9).
- From that state, `seg_shift` alone with `seg_dir`=1:
  - digit 3 becomes blank (0xFF);
  - digit 0 shows 0xF8 (7).
- `seg_clear` and `seg_write` (value A) in the same cycle: all digits read 0xFF on the next frame.
- Write 0 to digit 0, then assert `seg_off` for 20 cycles:
  - `anodes` = 0xF throughout;
  - after release, the scan resumes at the correct phase and digit 0 shows 0xC0.
- `rst` asserted mid-frame with a full buffer: both outputs inactive one edge later, and the scan restarts at digit 0.
